// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request, single-entry
// instruction buffer toward decode, next-PC selection and misalignment trap.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    input  logic        pcSrc,
    input  logic [31:0] pc_target,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        HOLD,
        DISCARD,
        HALT
    } state_t;

    state_t      state;
    state_t      stateNext;
    state_t      redirState;
    logic [31:0] pc;
    logic [31:0] pcNext;
    logic [31:0] instrQ;
    logic [31:0] instrNext;
    logic [31:0] pcOutQ;
    logic [31:0] pcOutNext;
    logic [31:0] selPc;
    logic        fault;
    logic        faultNext;
    logic        live;
    logic        consume;
    logic        doRedirect;
    logic        misaligned;

    assign consume    = (state == HOLD) && decode_ready;
    assign selPc      = flush ? flush_pc : (pcSrc ? pc_target : pcOutQ + 32'd4);
    assign misaligned = |selPc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            instrQ <= 32'h0000_0013;
            pcOutQ <= 32'h0;
            fault  <= 1'b0;
            live   <= 1'b0;
        end else begin
            state  <= stateNext;
            pc     <= pcNext;
            instrQ <= instrNext;
            pcOutQ <= pcOutNext;
            fault  <= faultNext;
            live   <= 1'b1;
        end
    end

    always_comb begin
        stateNext  = state;
        pcNext     = pc;
        instrNext  = instrQ;
        pcOutNext  = pcOutQ;
        faultNext  = fault;
        doRedirect = 1'b0;
        redirState = FETCH;
        unique case (state)
            FETCH: begin
                // live gates the very first cycle out of reset
                if (live) begin
                    stateNext  = WAIT;
                    doRedirect = flush;
                    redirState = DISCARD;
                end
            end
            WAIT: begin
                if (flush) begin
                    doRedirect = 1'b1;
                    redirState = imem_rvalid ? FETCH : DISCARD;
                end else if (imem_rvalid) begin
                    instrNext = imem_rdata;
                    pcOutNext = pc;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                doRedirect = flush || consume;
                redirState = FETCH;
            end
            DISCARD: begin
                if (imem_rvalid) stateNext = FETCH;
                doRedirect = flush;
                redirState = imem_rvalid ? FETCH : DISCARD;
            end
            HALT: begin
                doRedirect = flush;
                redirState = FETCH;
            end
            default: stateNext = HALT;
        endcase
        if (doRedirect) begin
            if (misaligned) begin
                faultNext = 1'b1;
                stateNext = HALT;
            end else begin
                pcNext    = selPc;
                stateNext = redirState;
            end
        end
    end

    assign imem_req    = live && (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);
    assign instr       = instrQ;
    assign pc_out      = pcOutQ;
    assign op          = instrQ[6:0];
    assign funct3      = instrQ[14:12];
    assign funct7      = instrQ[30];
    assign fetch_fault = fault;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the RISC-V core, directly upstream of `control_unit`. Holds the PC, issues word reads to instruction memory over a request/response interface, and buffers each returned instruction until decode accepts it. Presents the `op`, `funct3` and `funct7` bit-5 fields to `control_unit`. Applies `control_unit`'s `pcSrc` decision, or an external flush, to select the next PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, valid for one cycle per fetch.
- `imem_addr` out 32: fetch address; equals `pc` while `imem_req`=1.
- `imem_rvalid` in 1: response valid; at most one response per request.
- `imem_rdata` in 32: returned instruction, sampled when `imem_rvalid`=1.
- `instr_valid` out 1: the `instr`, `pc_out`, `op`, `funct3` and `funct7` outputs hold a live instruction.
- `decode_ready` in 1: decode accepts the instruction this cycle.
- `instr` out 32: buffered instruction.
- `pc_out` out 32: PC of `instr`.
- `op` out 7: `instr[6:0]`.
- `funct3` out 3: `instr[14:12]`.
- `funct7` out 1: `instr[30]`.
- `pcSrc` in 1: from `control_unit`; 1 selects `pc_target`. Sampled only on consume.
- `pc_target` in 32: branch/jump target.
- `flush` in 1: redirect from trap/ECALL logic; highest priority.
- `flush_pc` in 32: redirect address.
- `fetch_fault` out 1: sticky; set when a misaligned next-PC is selected.

## Operation
- Registers:
  - `pc`
  - `instr` buffer
  - `pc_out`
  - 3-bit state: FETCH, WAIT, HOLD, DISCARD, HALT.
- Consume event: `instr_valid`=1 and `decode_ready`=1.
- Next-PC selection:
  - `flush`=1 gives `flush_pc`.
  - Otherwise, on consume: `pcSrc`=1 gives `pc_target`; `pcSrc`=0 gives `pc_out + 4`, computed modulo 2^32 (wraps from 32'hFFFF_FFFC to 0).
- Any selected next-PC with bits [1:0] ≠ 0: set `fetch_fault`, enter HALT, leave `pc` unchanged.
- State behaviour:
  - **FETCH**: `imem_req`=1, `imem_addr`=`pc`. Go to WAIT. If `flush` is also 1: `pc`←`flush_pc` and go to DISCARD, because the request already issued with the old PC.
  - **WAIT**: `imem_req`=0. On `imem_rvalid`: `instr`←`imem_rdata`, `pc_out`←`pc`, go to HOLD.
  - **HOLD**: `instr_valid`=1. On consume: `pc`←next-PC, go to FETCH. Without consume, all outputs hold stable.
  - **DISCARD**: wait for the stale response, drop it, go to FETCH. A `flush` here updates `pc` and stays in DISCARD.
  - **HALT**: `imem_req`=0, `instr_valid`=0. Only `flush` with an aligned `flush_pc` exits, to FETCH; `fetch_fault` stays set until reset.
- `flush` in WAIT: `pc`←`flush_pc`, go to DISCARD.
- `flush` in HOLD: drop the instruction (`instr_valid`=0 next cycle), `pc`←`flush_pc`, go to FETCH. `flush` wins over a same-cycle consume; `pcSrc` is ignored.
- `imem_rvalid` in FETCH or HOLD is a protocol violation; ignore it.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`, state FETCH.
  - `imem_req`=0 during reset; asserts in the first cycle after release.
  - `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `pc_out`=0, `fetch_fault`=0.
  - `op`, `funct3` and `funct7` follow `instr`: 7'b0010011, 3'b000, 0.
- `imem_req`, `imem_addr` and `instr_valid` decode from registered state only; no combinational path from any input.
- Minimum fetch-to-valid latency is 2 cycles: request in cycle N, `imem_rvalid` in N+1, `instr_valid` in N+2.
- Throughput with zero-wait memory and `decode_ready` held at 1: one instruction per 3 cycles.
- Reset asserted mid-WAIT drops the outstanding response. Memory is reset on the same `rst_n`.

## Test plan
- **Reset then fetch**: release `rst_n`; memory returns 32'h00000033 one cycle after the request.
  - `imem_addr`=0 in cycle 1; `instr_valid`=1 in cycle 3.
  - `op`=7'b0110011, `funct3`=0, `funct7`=0, `pc_out`=0.
- **Sequential fetch**: hold `decode_ready`=1 and `pcSrc`=0 for 3 instructions.
  - `imem_addr` sequence 0, 4, 8.
  - `instr_valid` pulses are 3 cycles apart.
- **Backpressure**: hold `decode_ready`=0 for 5 cycles in HOLD.
  - `instr` and `pc_out` stay stable; no `imem_req`.
  - Release: next `imem_addr`=`pc_out`+4.
- **Branch taken**: instruction 32'h00000063 at PC 8, `pcSrc`=1, `pc_target`=32'h40, consumed.
  - Next `imem_addr`=32'h40.
- **Flush during WAIT**: `flush`=1, `flush_pc`=32'h100; the stale response arrives 2 cycles later.
  - The stale response is dropped with no `instr_valid`.
  - Next `imem_addr`=32'h100.
- **Misaligned target**: `pc_target`=32'h42 with `pcSrc`=1 on consume.
  - `fetch_fault`=1, `imem_req` stays 0.
  - `flush` with `flush_pc`=32'h200 then resumes fetching at 32'h200 with `fetch_fault` still 1.
